// File: rtl/csa_8bit_pkg.sv
// Shared constants for the 8-bit carry-select adder.
// The block is built for one fixed geometry: two 4-bit slices.
package csa_8bit_pkg;

   localparam int CSA_WIDTH = 8;
   localparam int CSA_BLOCK = 4;

endpackage : csa_8bit_pkg

// File: rtl/csa_8bit_rca_4bit.sv
// 4-bit ripple-carry adder built from per-bit full-adder equations.
// It is the building block for the lower slice and both upper candidates.
module rca_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic carry;

   // The carry is kept in a local variable so the chain stays inside one
   // process rather than forming a bit-level feedback vector.
   always_comb begin
      s     = '0;
      carry = cin;
      for (int i = 0; i < 4; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule : rca_4bit

// File: rtl/csa_8bit.sv
// 8-bit carry-select adder with a registered {cout,sum}; one-cycle latency.
// There is no handshake: a, b, cin are sampled on every rising edge.
module csa_8bit
   import csa_8bit_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH,
   parameter int BLOCK = CSA_BLOCK
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   input  logic             clk,
   input  logic             rst
);

   logic [BLOCK-1:0] s_lo;
   logic             c4;
   logic [BLOCK-1:0] s_hi0;
   logic [BLOCK-1:0] s_hi1;
   logic             c8_0;
   logic             c8_1;

   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_d;
   logic             cout_q;

   rca_4bit u_rca_lo (
      .a    (a[BLOCK-1:0]),
      .b    (b[BLOCK-1:0]),
      .cin  (cin),
      .s    (s_lo),
      .cout (c4)
   );

   // Both upper candidates are computed in parallel; c4 only picks one.
   rca_4bit u_rca_hi0 (
      .a    (a[WIDTH-1:BLOCK]),
      .b    (b[WIDTH-1:BLOCK]),
      .cin  (1'b0),
      .s    (s_hi0),
      .cout (c8_0)
   );

   rca_4bit u_rca_hi1 (
      .a    (a[WIDTH-1:BLOCK]),
      .b    (b[WIDTH-1:BLOCK]),
      .cin  (1'b1),
      .s    (s_hi1),
      .cout (c8_1)
   );

   always_comb begin
      sum_d  = {(c4 ? s_hi1 : s_hi0), s_lo};
      cout_d = c4 ? c8_1 : c8_0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : csa_8bit

// File: tb/tb_csa_8bit.sv
// Directed and random checks of csa_8bit: reset, basic adds, carry select,
// overflow, result hold, back-to-back stream and mid-stream reset.
module tb_csa_8bit;

   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [7:0] sum;
   logic       cout;
   logic       clk;
   logic       rst;

   int total;
   int bad;
   logic [8:0] exp_q[$];

   csa_8bit dut (
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .clk  (clk),
      .rst  (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] es, input logic ec);
      total++;
      assert (sum === es && cout === ec) else begin
         bad++;
         $error("FAIL %s: got sum=%0d cout=%0b, want sum=%0d cout=%0b",
                tag, sum, cout, es, ec);
      end
   endtask

   // Drive inputs on the falling edge, away from the sampling edge.
   task automatic drive(input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic c_v, input logic r_v);
      @(negedge clk);
      a   = a_v;
      b   = b_v;
      cin = c_v;
      rst = r_v;
   endtask

   task automatic step_check(input string tag, input logic [7:0] es, input logic ec);
      @(posedge clk);
      #1;
      check(tag, es, ec);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      a     = 8'd77;
      b     = 8'd99;
      cin   = 1'b1;
      rst   = 1'b0;

      // Reset held for two edges with non-zero operands present.
      step_check("reset_edge1", 8'd0, 1'b0);
      step_check("reset_edge2", 8'd0, 1'b0);

      // First edge after release registers the current operands.
      drive(8'd2, 8'd5, 1'b0, 1'b1);
      step_check("add_2_5", 8'd7, 1'b0);

      // Output holds between edges even though the inputs already changed.
      drive(8'd1, 8'd1, 1'b0, 1'b1);
      #1;
      check("hold_7", 8'd7, 1'b0);
      step_check("add_1_1", 8'd2, 1'b0);

      drive(8'd20, 8'd20, 1'b1, 1'b1);
      step_check("add_20_20_c", 8'd41, 1'b0);
      drive(8'd75, 8'd75, 1'b1, 1'b1);
      step_check("add_75_75_c", 8'd151, 1'b0);

      drive(8'd128, 8'd128, 1'b0, 1'b1);
      step_check("ovf_128_128", 8'd0, 1'b1);
      drive(8'd255, 8'd255, 1'b1, 1'b1);
      step_check("ovf_255_255_c", 8'd255, 1'b1);
      drive(8'd200, 8'd20, 1'b0, 1'b1);
      step_check("add_200_20", 8'd220, 1'b0);
      drive(8'd15, 8'd1, 1'b0, 1'b1);
      step_check("add_15_1", 8'd16, 1'b0);
      drive(8'd240, 8'd15, 1'b1, 1'b1);
      step_check("add_240_15_c", 8'd0, 1'b1);

      // Back-to-back stream with a reset cycle in the middle.
      drive(8'd10, 8'd3, 1'b0, 1'b1);
      step_check("b2b_1", 8'd13, 1'b0);
      drive(8'd100, 8'd50, 1'b1, 1'b1);
      step_check("b2b_2", 8'd151, 1'b0);
      drive(8'd90, 8'd90, 1'b0, 1'b0);
      step_check("mid_reset", 8'd0, 1'b0);
      drive(8'd60, 8'd70, 1'b1, 1'b1);
      step_check("after_release", 8'd131, 1'b0);
      drive(8'd250, 8'd9, 1'b0, 1'b1);
      step_check("b2b_3", 8'd3, 1'b1);

      // Random stream against a 9-bit reference sum.
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         logic       rc;
         logic [8:0] ref_v;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         drive(ra, rb, rc, 1'b1);
         exp_q.push_back(9'(ra) + 9'(rb) + 9'(rc));
         @(posedge clk);
         #1;
         ref_v = exp_q.pop_front();
         check("random", ref_v[7:0], ref_v[8]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_csa_8bit
